// File: rtl/caf_peak_select.sv
// Tracks the largest x_corr magnitude across one frequency sweep and emits it with its lag, bin and threshold flag.
// Result is valid one cycle after the last bin's transfer; input is stalled (tready low) until the result is taken.
module caf_peak_select #(
   parameter int unsigned out_max_bits    = 5,
   parameter int unsigned index_bits      = 3,
   parameter int unsigned freq_bins       = 4,
   parameter int unsigned freq_index_bits = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       m_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [out_max_bits-1:0]    out_max,
   input  logic [index_bits-1:0]      index,
   input  logic [out_max_bits-1:0]    threshold,
   input  logic                       m_axis_tready,
   output logic                       s_axis_tvalid,
   output logic [out_max_bits-1:0]    peak_max,
   output logic [index_bits-1:0]      peak_time_index,
   output logic [freq_index_bits-1:0] peak_freq_index,
   output logic                       detect
);

   localparam logic [0:0] ST_ACCUM  = 1'b0;
   localparam logic [0:0] ST_OUTPUT = 1'b1;
   localparam logic [freq_index_bits-1:0] LAST_BIN = freq_index_bits'(freq_bins - 1);

   logic [0:0]                 state;
   logic [freq_index_bits-1:0] bin_count;
   logic [out_max_bits-1:0]    best_max;
   logic [index_bits-1:0]      best_time;
   logic [freq_index_bits-1:0] best_freq;

   logic                       xfer;
   logic                       take_new;
   logic [out_max_bits-1:0]    nxt_max;
   logic [index_bits-1:0]      nxt_time;
   logic [freq_index_bits-1:0] nxt_freq;

   // tready is only ever high in ACCUM, so it alone qualifies a transfer
   assign xfer = m_axis_tvalid & s_axis_tready;

   // Bin 0 overwrites stale state; later bins need a strict win so ties keep the earlier bin
   always_comb begin
      take_new = (bin_count == '0) || (out_max > best_max);
      nxt_max  = best_max;
      nxt_time = best_time;
      nxt_freq = best_freq;
      if (take_new) begin
         nxt_max  = out_max;
         nxt_time = index;
         nxt_freq = bin_count;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_ACCUM;
         bin_count       <= '0;
         best_max        <= '0;
         best_time       <= '0;
         best_freq       <= '0;
         s_axis_tready   <= 1'b0;
         s_axis_tvalid   <= 1'b0;
         peak_max        <= '0;
         peak_time_index <= '0;
         peak_freq_index <= '0;
         detect          <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               s_axis_tready <= 1'b1;
               if (xfer) begin
                  best_max  <= nxt_max;
                  best_time <= nxt_time;
                  best_freq <= nxt_freq;
                  if (bin_count == LAST_BIN) begin
                     peak_max        <= nxt_max;
                     peak_time_index <= nxt_time;
                     peak_freq_index <= nxt_freq;
                     detect          <= (nxt_max >= threshold);
                     s_axis_tvalid   <= 1'b1;
                     s_axis_tready   <= 1'b0;
                     bin_count       <= '0;
                     state           <= ST_OUTPUT;
                  end else begin
                     bin_count <= bin_count + freq_index_bits'(1);
                  end
               end
            end
            ST_OUTPUT: begin
               if (m_axis_tready) begin
                  s_axis_tvalid <= 1'b0;
                  s_axis_tready <= 1'b1;
                  state         <= ST_ACCUM;
               end
            end
            default: begin
               state <= ST_ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_caf_peak_select.sv
// Bench for caf_peak_select: table of sweeps checked through an expected-result queue, plus hand-written corner sequences.
module tb_caf_peak_select;

   logic       clk;
   logic       rst_n;
   logic       m_axis_tvalid;
   logic       s_axis_tready;
   logic [4:0] out_max;
   logic [2:0] index;
   logic [4:0] threshold;
   logic       m_axis_tready;
   logic       s_axis_tvalid;
   logic [4:0] peak_max;
   logic [2:0] peak_time_index;
   logic [1:0] peak_freq_index;
   logic       detect;

   caf_peak_select #(
      .out_max_bits(5), .index_bits(3), .freq_bins(4), .freq_index_bits(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
      .out_max(out_max), .index(index), .threshold(threshold),
      .m_axis_tready(m_axis_tready), .s_axis_tvalid(s_axis_tvalid),
      .peak_max(peak_max), .peak_time_index(peak_time_index),
      .peak_freq_index(peak_freq_index), .detect(detect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][4:0] om;
      logic [3:0][2:0] ix;
      int              gap_bin;
      int              gap_len;
      logic [4:0]      thr;
      logic [4:0]      e_max;
      logic [2:0]      e_time;
      logic [1:0]      e_freq;
      logic            e_det;
   } vec_t;

   typedef struct {
      logic [4:0] e_max;
      logic [2:0] e_time;
      logic [1:0] e_freq;
      logic       e_det;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(int o0, int i0, int o1, int i1, int o2, int i2, int o3, int i3,
                               int gb, int gl, int thr, int em, int et, int ef, int ed);
      vec_t v;
      v.om[0] = 5'(o0); v.ix[0] = 3'(i0);
      v.om[1] = 5'(o1); v.ix[1] = 3'(i1);
      v.om[2] = 5'(o2); v.ix[2] = 3'(i2);
      v.om[3] = 5'(o3); v.ix[3] = 3'(i3);
      v.gap_bin = gb; v.gap_len = gl;
      v.thr = 5'(thr);
      v.e_max = 5'(em); v.e_time = 3'(et); v.e_freq = 2'(ef); v.e_det = ed[0];
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one bin and hold it until the DUT takes it on a rising edge
   task automatic send_bin(input logic [4:0] o, input logic [2:0] i);
      int w;
      m_axis_tvalid = 1'b1;
      out_max       = o;
      index         = i;
      w = 0;
      while (!s_axis_tready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("bin_accept", int'(s_axis_tready), 1);
      chk("no_early_valid", int'(s_axis_tvalid), 0);
      @(negedge clk);
   endtask

   task automatic check_result();
      exp_t e;
      chk("latency_tvalid", int'(s_axis_tvalid), 1);
      chk("output_tready", int'(s_axis_tready), 0);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("peak_max", int'(peak_max), int'(e.e_max));
         chk("peak_time_index", int'(peak_time_index), int'(e.e_time));
         chk("peak_freq_index", int'(peak_freq_index), int'(e.e_freq));
         chk("detect", int'(detect), int'(e.e_det));
      end
   endtask

   task automatic handoff();
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
      chk("handoff_tvalid", int'(s_axis_tvalid), 0);
      chk("handoff_tready", int'(s_axis_tready), 1);
   endtask

   task automatic run_sweep(input vec_t v, input bit do_handoff);
      exp_t e;
      threshold = v.thr;
      e.e_max = v.e_max; e.e_time = v.e_time; e.e_freq = v.e_freq; e.e_det = v.e_det;
      sb.push_back(e);
      for (int b = 0; b < 4; b++) begin
         if (b == v.gap_bin && v.gap_len > 0) begin
            m_axis_tvalid = 1'b0;
            repeat (v.gap_len) @(negedge clk);
         end
         send_bin(v.om[b], v.ix[b]);
      end
      m_axis_tvalid = 1'b0;
      check_result();
      if (do_handoff) handoff();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t bp_next;
      vecs[0] = mk(3,1, 12,4, 7,2, 9,0,   0,0, 10, 12,4,1,1);  // basic
      vecs[1] = mk(8,2, 8,5, 8,6, 8,7,    0,0,  9,  8,2,0,0);  // ties keep bin 0
      vecs[2] = mk(3,1, 12,4, 7,2, 9,0,   2,3, 10, 12,4,1,1);  // idle gap before bin 2
      vecs[3] = mk(15,3, 4,1, 15,6, 1,0,  0,0, 15, 15,3,0,1);  // threshold equal
      vecs[4] = mk(15,3, 4,1, 15,6, 1,0,  0,0, 16, 15,3,0,0);  // threshold above
      vecs[5] = mk(0,0, 1,1, 2,2, 3,5,    0,0,  3,  3,5,3,1);  // max in last bin
      vecs[6] = mk(0,1, 0,2, 0,3, 0,4,    0,0,  0,  0,1,0,1);  // bin 0 overrides stale best

      rst_n = 1'b0; m_axis_tvalid = 1'b0; out_max = '0; index = '0;
      threshold = '0; m_axis_tready = 1'b0;
      #2;
      chk("rst_tready", int'(s_axis_tready), 0);
      chk("rst_tvalid", int'(s_axis_tvalid), 0);
      chk("rst_peak_max", int'(peak_max), 0);
      chk("rst_time", int'(peak_time_index), 0);
      chk("rst_freq", int'(peak_freq_index), 0);
      chk("rst_detect", int'(detect), 0);
      #6 rst_n = 1'b1;
      @(negedge clk);
      chk("tready_before_edge", int'(s_axis_tready), 0);
      @(negedge clk);
      chk("tready_after_edge", int'(s_axis_tready), 1);

      for (int k = 0; k < 7; k++) run_sweep(vecs[k], 1'b1);

      // Backpressure: result held while upstream keeps offering a bin
      run_sweep(vecs[0], 1'b0);
      m_axis_tvalid = 1'b1; out_max = 5'd5; index = 3'd7;
      repeat (5) begin
         @(negedge clk);
         chk("bp_tready", int'(s_axis_tready), 0);
         chk("bp_tvalid", int'(s_axis_tvalid), 1);
         chk("bp_peak_max", int'(peak_max), int'(vecs[0].e_max));
         chk("bp_time", int'(peak_time_index), int'(vecs[0].e_time));
         chk("bp_freq", int'(peak_freq_index), int'(vecs[0].e_freq));
         chk("bp_detect", int'(detect), int'(vecs[0].e_det));
      end
      handoff();
      bp_next = mk(5,7, 6,1, 2,2, 20,6, 0,0, 25, 20,6,3,0);
      run_sweep(bp_next, 1'b1);

      // Reset mid-sweep, asserted between clock edges
      threshold = 5'd10;
      send_bin(5'd30, 3'd1);
      send_bin(5'd29, 3'd2);
      m_axis_tvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_peak_max", int'(peak_max), 0);
      chk("mid_rst_time", int'(peak_time_index), 0);
      chk("mid_rst_freq", int'(peak_freq_index), 0);
      chk("mid_rst_tready", int'(s_axis_tready), 0);
      chk("mid_rst_tvalid", int'(s_axis_tvalid), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_sweep(mk(1,0, 2,1, 31,3, 0,0, 0,0, 10, 31,3,2,1), 1'b1);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
